// File: rtl/data_memory_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl_if
// Request/response bus between the load/store stage and the data memory.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_we              : 0 = read, 1 = write
//   req_addr            : word address
//   req_wdata/req_be    : write data and per-byte enables
//   rsp_valid/rsp_ready : read-response handshake
//   rsp_rdata/rsp_err   : read data, error flag for out-of-range reads
// master : the requester (load/store stage)
// slave  : the memory controller
// ---------------------------------------------------------------------------
interface data_memory_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// ---------------------------------------------------------------------------
// data_memory_ctrl
// Single-port data memory with a valid/ready request channel, a registered
// read-response channel with backpressure (one response slot), per-byte
// write enables, and a one-word-per-cycle clear sequence after reset.
//
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous, active-high
//   bus       : data_memory_ctrl_if.slave request/response bus
//   init_done : clear sequence finished, memory is serving requests
//   wr_err    : one-cycle pulse, an out-of-range write was accepted and dropped
//
// Optional feature macro: DMEM_PRELOAD_EN
//   When defined, the clear sequence writes 1, 0x10 and 0x11 into words 0, 1
//   and 2 instead of zero. The clear length is unchanged.
// ---------------------------------------------------------------------------
module data_memory_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic               clk,
   input  logic               reset,
   data_memory_ctrl_if.slave  bus,
   output logic               init_done,
   output logic               wr_err
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // One extra bit so DEPTH == 2**ADDR_W is representable for the range test.
   localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [0:0]        state_q,     state_d;
   logic [IDX_W-1:0]  clr_cnt_q,   clr_cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;
   logic              init_done_q, init_done_d;
   logic              wr_err_q,    wr_err_d;

   logic              req_ready;
   logic              req_accept;
   logic              addr_in_range;
   logic [IDX_W-1:0]  req_idx;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BE_W-1:0]   mem_wbe;

   // Single response slot: a new request fits only if the slot is empty or
   // is being drained this very cycle.
   assign req_ready     = (state_q == ST_RUN) && (!rsp_valid_q || bus.rsp_ready);
   assign req_accept    = bus.req_valid && req_ready;
   assign addr_in_range = {1'b0, bus.req_addr} < DEPTH_L;
   assign req_idx       = bus.req_addr[IDX_W-1:0];

   // Next-state logic: clear sequencing in INIT, request handling in RUN.
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      wr_err_d    = 1'b0;
      mem_we      = 1'b0;
      mem_waddr   = req_idx;
      mem_wdata   = bus.req_wdata;
      mem_wbe     = bus.req_be;

      if (state_q == ST_INIT) begin
         mem_we    = 1'b1;
         mem_waddr = clr_cnt_q;
         mem_wbe   = '1;
         mem_wdata = '0;
`ifdef DMEM_PRELOAD_EN
         if (clr_cnt_q == IDX_W'(0)) mem_wdata = DATA_W'(32'h0000_0001);
         if (clr_cnt_q == IDX_W'(1)) mem_wdata = DATA_W'(32'h0000_0010);
         if (clr_cnt_q == IDX_W'(2)) mem_wdata = DATA_W'(32'h0000_0011);
`endif
         if (clr_cnt_q == LAST_IDX) begin
            state_d = ST_RUN;
         end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
         end
      end else begin
         if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
         end
         if (req_accept) begin
            if (bus.req_we) begin
               // Out-of-range writes are swallowed and flagged.
               mem_we   = addr_in_range;
               wr_err_d = !addr_in_range;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = !addr_in_range;
               rsp_rdata_d = addr_in_range ? mem_q[req_idx] : '0;
            end
         end
      end

      init_done_d = (state_d == ST_RUN);
   end

   // Control and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_INIT;
         clr_cnt_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         init_done_q <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         init_done_q <= init_done_d;
         wr_err_q    <= wr_err_d;
      end
   end

   // Storage array; no reset here, the INIT sequence clears it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < BE_W; k++) begin
            if (mem_wbe[k]) begin
               mem_q[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign init_done     = init_done_q;
   assign wr_err        = wr_err_q;
endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised single-port data memory with a valid/ready request channel, a registered read-response channel with backpressure, per-byte write enables and hardware clear-on-reset. It replaces the fixed 1024×32 data memory in the CPU datapath. It serves the load/store stage through a handshake rather than a bare enable/rw pair. After reset it clears the array one word per cycle, instead of in a single clock.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 10, word-address width
- DEPTH, 1024, implemented words; DEPTH ≤ 2^ADDR_W
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high together with req_valid
- req_we  in  1  0 = read, 1 = write
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; bit k writes bits [8k+7:8k]
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer takes rsp_rdata when high together with rsp_valid
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  qualifies rsp_valid; the read address was ≥ DEPTH
- init_done  out  1  clear sequence finished
- wr_err  out  1  one-cycle pulse; a write to an address ≥ DEPTH was accepted and dropped

## Operation
- States: INIT, RUN.
- reset forces INIT. It also sets clr_cnt=0, drops any pending response, and sets all outputs to 0: req_ready, rsp_valid, rsp_rdata, rsp_err, init_done and wr_err.
- INIT:
  - Each cycle writes 0 to mem[clr_cnt], with all bytes enabled, and increments clr_cnt.
  - When clr_cnt reaches DEPTH-1 and that word is written, the block moves to RUN.
  - req_ready is 0 for the whole of INIT.
- RUN:
  - init_done=1.
  - req_ready = !rsp_valid || rsp_ready, so there is a single response slot.
- Accepted write:
  - For each k with req_be[k]=1, mem[addr] byte k is set to req_wdata byte k. Other bytes are held.
  - No response is produced.
  - If addr ≥ DEPTH, the write is dropped and wr_err pulses on the next cycle.
- Accepted read:
  - rsp_rdata=mem[addr] and rsp_valid=1 from the next cycle.
  - If addr ≥ DEPTH, rsp_rdata=0 and rsp_err=1.
- rsp_valid, rsp_rdata and rsp_err hold steady until rsp_valid && rsp_ready.
- In the cycle the response is taken, a new read may be accepted. rsp_valid then stays 1 and carries the new data with no bubble.
- A write accepted in the cycle the response is taken does not produce a response; rsp_valid falls.
- Read-after-write to the same address, on consecutive accepted requests, returns the new data. The write commits at the accepting edge.
- req_be=0 on a write: the request is accepted and memory is unchanged.
- While req_valid && !req_ready, the inputs are ignored. The requester must hold them.
- Reset asserted mid-INIT or mid-RUN: the sequence restarts from clr_cnt=0, and any in-flight response is lost.

## Timing
- Clear: after the reset-release edge, INIT lasts exactly DEPTH cycles. init_done and req_ready rise on cycle DEPTH+1.
- Read latency: 1 cycle from the accept edge to rsp_valid.
- Throughput: 1 request per cycle while rsp_ready=1, or while only writes are issued.
- wr_err: a single-cycle pulse, 1 cycle after the accept.
- Every output is registered except req_ready, which is combinational from state, rsp_valid and rsp_ready.

## Configuration
- DMEM_PRELOAD_EN defined:
  - During INIT, addresses 0, 1 and 2 are written with 32'h00000001, 32'h00000010 and 32'h00000011. These values are zero-extended or truncated to DATA_W.
  - All other words are cleared to 0.
  - INIT length is unchanged.
- DMEM_PRELOAD_EN undefined: every word is cleared to 0.

## Test plan
- Reset for 2 cycles, then release with DEPTH=1024 -> init_done=0 and req_ready=0 for 1024 cycles, then both are 1. Reading addresses 0/1/2 returns 0x1/0x10/0x11 with DMEM_PRELOAD_EN defined, and 0 without it.
- Write 0xDEADBEEF to address 5 with be=4'hF, then write 0x000000AA with be=4'b0001, then read address 5 -> rsp_rdata=0xDEADBEAA one cycle after the read is accepted.
- Back-to-back reads of addresses 7, 8, 9 with rsp_ready=1 -> rsp_valid is high for 3 consecutive cycles with the data in order. With rsp_ready=0 held 4 cycles after the first read -> req_ready=0 and rsp_rdata stays mem[7] throughout.
- DEPTH=1000, ADDR_W=10: read address 1010 -> rsp_valid=1, rsp_err=1, rsp_rdata=0. Write address 1010 -> wr_err pulses 1 cycle and mem[1010 mod anything] is unchanged.
- Assert reset at clear count 500, then release -> init_done rises exactly 1024 cycles after release.
- Assert reset while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 after the reset edge, and that response is never delivered.
